// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a byte stream (16-bit big-endian word count, then
// big-endian 32-bit words) into word writes from address 0 upward. Holds the CPU while
// loading, pulses done on success and latches error on a bad header or checksum.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StData,
        StWrite,
`ifdef IMEM_LOADER_CHECKSUM_EN
        StCsum,
`endif
        StDone,
        StErr
    } state_e;

    // State entered once the last word (or an empty header) has been handled.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e StFinish = StCsum;
`else
    localparam state_e StFinish = StDone;
`endif

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic [15:0]       n_full;
    logic [ADDR_W:0]   idx_next;

    assign n_full   = {n_q[15:8], in_data};
    assign idx_next = (ADDR_W + 1)'(index_q) + 1'b1;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            n_q        <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            index_q    <= '0;
            words_q    <= '0;
            error_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            index_q    <= index_d;
            words_q    <= words_d;
            error_q    <= error_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        index_d    = index_q;
        words_d    = words_q;
        error_d    = error_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        in_ready   = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            StIdle, StErr: begin
                if (start) begin
                    state_d    = StHdrHi;
                    words_d    = '0;
                    error_d    = 1'b0;
                    index_d    = '0;
                    byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            StHdrHi: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    n_d[15:8] = in_data;
                    state_d   = StHdrLo;
                end
            end
            StHdrLo: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    n_d[7:0] = in_data;
                    if (n_full == 16'd0) begin
                        state_d = StFinish;
                    end else if (32'(n_full) > DEPTH) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d     = {word_q[23:0], in_data};
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ in_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Latch the write port here so it holds after the WRITE cycle.
                        state_d = StWrite;
                        waddr_d = index_q;
                        wdata_d = {word_q[23:0], in_data};
                    end
                end
            end
            StWrite: begin
                mem_we  = 1'b1;
                index_d = index_q + 1'b1;
                words_d = words_q + 1'b1;
                if (32'(idx_next) == 32'(n_q)) begin
                    state_d = StFinish;
                end else begin
                    state_d = StData;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCsum: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_data == csum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        cpu_hold = (state_q != StIdle);
        busy     = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                   (state_q == StData) || (state_q == StWrite);
        done     = (state_q == StDone);
    end

    assign error        = error_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with ADDR_W = 8.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] words_loaded;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int done_unheld = 0;
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];

    imem_loader #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wa_q.push_back(mem_waddr);
                wd_q.push_back(mem_wdata);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                if (!cpu_hold) done_unheld = done_unheld + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Present one byte and hold it until accepted; returns at posedge+1 after acceptance.
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("byte_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_done(input int base);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_cnt > base) break;
        end
        repeat (3) @(negedge clk);
        check("done_once", 64'(done_cnt - base), 64'd1);
    endtask

    // Standard 2-word program, optional idle gap between bytes 2 and 3 of word 0.
    task automatic load_std(input int gap);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h08);
        repeat (gap) begin
            @(posedge clk); #1;
        end
        send_byte(8'h00);
        send_byte(8'h05);
        // Write pulse lands the cycle after the 4th byte is accepted.
        check("lat_we", 64'(mem_we), 64'd1);
        check("lat_addr", 64'(mem_waddr), 64'd0);
        check("lat_data", 64'(mem_wdata), 64'h2008_0005);
        send_byte(8'h8C);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h04);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hA4);
`endif
    endtask

    task automatic verify_std(input int wbase);
        check("wr_count", 64'(wa_q.size() - wbase), 64'd2);
        if (wa_q.size() >= wbase + 2) begin
            check("wr0_addr", 64'(wa_q[wbase]), 64'd0);
            check("wr0_data", 64'(wd_q[wbase]), 64'h2008_0005);
            check("wr1_addr", 64'(wa_q[wbase+1]), 64'd1);
            check("wr1_data", 64'(wd_q[wbase+1]), 64'h8C01_0004);
        end
        check("words_loaded", 64'(words_loaded), 64'd2);
        check("hold_after", 64'(cpu_hold), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("error_after", 64'(error), 64'd0);
        check("we_after", 64'(mem_we), 64'd0);
        check("addr_held", 64'(mem_waddr), 64'd1);
        check("data_held", 64'(mem_wdata), 64'h8C01_0004);
    endtask

    initial begin
        int wbase;
        int dbase;

        // 1. Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_we", 64'(mem_we), 64'd0);
        check("rst_addr", 64'(mem_waddr), 64'd0);
        check("rst_data", 64'(mem_wdata), 64'd0);
        check("rst_hold", 64'(cpu_hold), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_words", 64'(words_loaded), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // start with in_valid in IDLE: byte must not be taken, loader now in HDR_HI.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        pulse_start();
        in_valid = 1'b0;
        check("hdr_ready", 64'(in_ready), 64'd1);
        check("hdr_busy", 64'(busy), 64'd1);
        check("hdr_hold", 64'(cpu_hold), 64'd1);

        // 2. Back-to-back load.
        wbase = wa_q.size();
        dbase = done_cnt;
        load_std(0);
        wait_done(dbase);
        verify_std(wbase);
        check("done_held_cpu", 64'(done_unheld), 64'd0);

        // 3. Same load with a 3-cycle stall mid-word.
        wbase = wa_q.size();
        dbase = done_cnt;
        pulse_start();
        load_std(3);
        wait_done(dbase);
        verify_std(wbase);

        // 4a. N == DEPTH is legal: header accepted, then aborted by reset.
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        check("ndepth_busy", 64'(busy), 64'd1);
        check("ndepth_error", 64'(error), 64'd0);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // 4b. N == DEPTH+1 -> ERR; then start from ERR reloads.
        wbase = wa_q.size();
        dbase = done_cnt;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        repeat (3) @(negedge clk);
        check("err_error", 64'(error), 64'd1);
        check("err_hold", 64'(cpu_hold), 64'd1);
        check("err_ready", 64'(in_ready), 64'd0);
        check("err_busy", 64'(busy), 64'd0);
        check("err_no_we", 64'(wa_q.size() - wbase), 64'd0);
        check("err_no_done", 64'(done_cnt - dbase), 64'd0);
        pulse_start();
        check("err_cleared", 64'(error), 64'd0);
        load_std(0);
        wait_done(dbase);
        verify_std(wbase);

        // 5a. Empty program.
        wbase = wa_q.size();
        dbase = done_cnt;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_done(dbase);
        check("empty_words", 64'(words_loaded), 64'd0);
        check("empty_no_we", 64'(wa_q.size() - wbase), 64'd0);

        // 5b. Reset after 6 data bytes of a 2-word load.
        wbase = wa_q.size();
        dbase = done_cnt;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h8C);
        send_byte(8'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_hold", 64'(cpu_hold), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_words", 64'(words_loaded), 64'd0);
        check("mid_rst_addr", 64'(mem_waddr), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt - dbase), 64'd0);
        check("mid_rst_one_we", 64'(wa_q.size() - wbase), 64'd1);
        check("mid_rst_idle_ready", 64'(in_ready), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6. Wrong checksum byte -> ERR.
        dbase = done_cnt;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h08);
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h8C);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h04);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check("csum_bad_error", 64'(error), 64'd1);
        check("csum_bad_no_done", 64'(done_cnt - dbase), 64'd0);
        check("csum_bad_hold", 64'(cpu_hold), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
